i2c_bus_arbiter: RTL
====================

Name: i2c_bus_arbiter

Overview:
- Shares the single FMC424 I2C bus between NUM_REQ requester FSMs on a round-robin basis.
- Monitors the glitch-filtered SCL/SDA lines to detect START and STOP conditions, and tracks whether the bus is busy.
- Issues a grant only after the bus has been free for the I2C bus-free time (tBUF).
- Sits between the ff_filter outputs and the per-device I2C transaction FSMs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BUS_FREE_CYCLES, 735, clk cycles of idle bus required before a grant (4.7 us at 156.25 MHz).
- START_TIMEOUT_CYCLES, 1563, max cycles from grant to an observed START before the grant is revoked (10 us).

Ports:
- clk  in  1  system clock, 156.25 MHz.
- rst  in  1  synchronous reset, active-high.
- scl_f  in  1  filtered SCL.
- sda_f  in  1  filtered SDA.
- req  in  NUM_REQ  per-requester bus request; level, held until done.
- done  in  NUM_REQ  per-requester single-cycle release pulse, issued after the requester's STOP.
- grant  out  NUM_REQ  one-hot grant, registered.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last grantee.
- bus_busy  out  1  high between an observed START and the next STOP.
- start_det  out  1  one-cycle pulse on a START condition.
- stop_det  out  1  one-cycle pulse on a STOP condition.
- timeout  out  1  one-cycle pulse when a grant is revoked for lack of a START.

Behaviour:
- Clock and reset:
  - Single clock domain; all state updates on posedge clk.
  - rst is synchronous and active-high.
- Reset values:
  - grant=0, grant_id=NUM_REQ-1 (so req[0] has first priority).
  - bus_busy=0, start_det=0, stop_det=0, timeout=0.
  - scl_q=1, sda_q=1, free_cnt=0, state=IDLE.
- Condition detect:
  - Previous-sample registers scl_q and sda_q.
  - START = scl_f & scl_q & sda_q & ~sda_f. STOP = scl_f & scl_q & ~sda_q & sda_f.
  - start_det and stop_det are registered, giving 1-cycle latency from the sample edge.
- bus_busy:
  - Set on START, cleared on STOP.
  - A repeated START while busy keeps it at 1.
- free_cnt:
  - Clears while bus_busy=1 or on any START.
  - Otherwise increments, saturating at BUS_FREE_CYCLES.
  - bus_free = (free_cnt==BUS_FREE_CYCLES) & ~bus_busy.
  - After reset the full tBUF must elapse before the first grant.
- FSM states: IDLE, GRANTED, RELEASE.
  - IDLE:
    - When |req & bus_free, select the first set req scanning from grant_id+1 with wrap-around.
    - Next cycle: grant one-hot asserted, grant_id updated, go to GRANTED.
    - Latency from the qualifying cycle to grant is 1 clk.
  - GRANTED:
    - Stay while req[grant_id]=1 and done[grant_id]=0.
    - On done[grant_id] or req[grant_id] deasserting: drop grant next cycle, go to RELEASE.
    - done and req falling in the same cycle count as a single release.
    - done/req from non-owners is ignored.
  - RELEASE:
    - Wait until bus_busy=0, then go to IDLE.
    - A new grant then also requires a full bus_free period, guaranteeing tBUF between masters.
- External multi-master START observed in IDLE:
  - bus_busy blocks any grant.
  - No grant is issued until STOP plus BUS_FREE_CYCLES.
- Invariants:
  - grant is never more than one-hot.
  - The round-robin pointer advances only on an issued grant.
- Reset mid-operation:
  - grant drops at the next clk edge.
  - All state returns to reset values regardless of bus state; bus_busy=0 until a new START is seen.

Optional Feature:
- Macro I2C_ARB_START_TIMEOUT_EN.
- Defined:
  - In GRANTED, a counter increments until a START is observed, then stops and stays cleared for the rest of the grant.
  - If the count reaches START_TIMEOUT_CYCLES: grant drops, timeout pulses for 1 cycle, the FSM goes to RELEASE, and the pointer stays on the revoked requester so the next requester gets priority.
- Not defined:
  - The counter logic is absent and timeout is tied to 0.
  - A grant is held until done or req deasserts.

Test Plan:
- Reset then req=4'b0001 with bus idle, BUS_FREE_CYCLES=8 → grant=0001 exactly 9 cycles after rst falls; grant_id=0.
- Owner 0 drives START (SDA fall with SCL high), data, then STOP, then pulses done → start_det and stop_det each pulse once, bus_busy high between them, grant drops 1 cycle after done.
- req=4'b1011 held, each owner completes a transaction → grant order 0, 1, 3, 0; each grant no earlier than 8 cycles after the preceding STOP.
- External START while IDLE with req=0010 → no grant while bus_busy=1; grant=0010 on the 9th cycle after the external STOP.
- rst asserted while grant=0100 mid-transaction → next cycle grant=0, bus_busy=0, grant_id=3; then req[0] is granted first.
- With I2C_ARB_START_TIMEOUT_EN, START_TIMEOUT_CYCLES=20, grant to 1 and no START → timeout pulses and grant drops at cycle 20; req=0011 still held → next grant goes to 0.

Source files
------------

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C bus between NUM_REQ requesters, gated by START/STOP tracking and tBUF.
// Optional START watchdog on granted masters: define I2C_ARB_START_TIMEOUT_EN.
module i2c_bus_arbiter #(
    parameter int NUM_REQ              = 4,
    parameter int BUS_FREE_CYCLES      = 735,
    parameter int START_TIMEOUT_CYCLES = 1563
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       scl_f,
    input  logic                       sda_f,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       bus_busy,
    output logic                       start_det,
    output logic                       stop_det,
    output logic                       timeout
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int FCW = $clog2(BUS_FREE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, GRANTED, RELEASE} state_t;

    state_t             state_q, state_d;
    logic               scl_q, sda_q;
    logic               start_det_q, stop_det_q;
    logic               bus_busy_q, bus_busy_d;
    logic [FCW-1:0]     free_cnt_q, free_cnt_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDW-1:0]     grant_id_q, grant_id_d;

    logic               start, stop, bus_free;
    logic               pick_found;
    logic [IDW-1:0]     pick_id;
    int unsigned        idx;

    assign start    = scl_f & scl_q & sda_q & ~sda_f;
    assign stop     = scl_f & scl_q & ~sda_q & sda_f;
    assign bus_free = (free_cnt_q == FCW'(BUS_FREE_CYCLES)) & ~bus_busy_q;

    always_comb begin
        bus_busy_d = bus_busy_q;
        if (start)
            bus_busy_d = 1'b1;
        else if (stop)
            bus_busy_d = 1'b0;

        free_cnt_d = free_cnt_q;
        if (bus_busy_q || start)
            free_cnt_d = '0;
        else if (free_cnt_q != FCW'(BUS_FREE_CYCLES))
            free_cnt_d = free_cnt_q + 1'b1;
    end

    // Round-robin scan starting one past the last grantee.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = grant_id_q;
        idx        = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = (32'(grant_id_q) + i) % NUM_REQ;
            if (!pick_found && req[IDW'(idx)]) begin
                pick_found = 1'b1;
                pick_id    = IDW'(idx);
            end
        end
    end

`ifdef I2C_ARB_START_TIMEOUT_EN
    localparam int TOW = $clog2(START_TIMEOUT_CYCLES + 1);
    logic [TOW-1:0] to_cnt_q, to_cnt_d;
    logic           started_q, started_d;
    logic           timeout_q, timeout_d;
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
`ifdef I2C_ARB_START_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
        started_d  = started_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus_free && pick_found) begin
                    grant_d          = '0;
                    grant_d[pick_id] = 1'b1;
                    grant_id_d       = pick_id;
                    state_d          = GRANTED;
`ifdef I2C_ARB_START_TIMEOUT_EN
                    to_cnt_d         = '0;
                    started_d        = 1'b0;
`endif
                end
            end
            GRANTED: begin
`ifdef I2C_ARB_START_TIMEOUT_EN
                if (!started_q) begin
                    if (start) begin
                        started_d = 1'b1;
                        to_cnt_d  = '0;
                    end else begin
                        to_cnt_d  = to_cnt_q + 1'b1;
                    end
                end
`endif
                if (done[grant_id_q] || !req[grant_id_q]) begin
                    grant_d = '0;
                    state_d = RELEASE;
                end
`ifdef I2C_ARB_START_TIMEOUT_EN
                // Pointer is left on the revoked requester so the scan moves past it.
                else if (!started_q && !start &&
                         to_cnt_q == TOW'(START_TIMEOUT_CYCLES - 1)) begin
                    grant_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = RELEASE;
                end
`endif
            end
            RELEASE: begin
                if (!bus_busy_q)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            scl_q       <= 1'b1;
            sda_q       <= 1'b1;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
            bus_busy_q  <= 1'b0;
            free_cnt_q  <= '0;
            grant_q     <= '0;
            grant_id_q  <= IDW'(NUM_REQ - 1);
`ifdef I2C_ARB_START_TIMEOUT_EN
            to_cnt_q    <= '0;
            started_q   <= 1'b0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            scl_q       <= scl_f;
            sda_q       <= sda_f;
            start_det_q <= start;
            stop_det_q  <= stop;
            bus_busy_q  <= bus_busy_d;
            free_cnt_q  <= free_cnt_d;
            grant_q     <= grant_d;
            grant_id_q  <= grant_id_d;
`ifdef I2C_ARB_START_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
            started_q   <= started_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign grant     = grant_q;
    assign grant_id  = grant_id_q;
    assign bus_busy  = bus_busy_q;
    assign start_det = start_det_q;
    assign stop_det  = stop_det_q;

endmodule
